// File: rtl/pmp_config_unit.sv
// PMP cfg/pmpaddr registers plus a one-entry-per-cycle range decoder; busy for NUM_PMP cycles after any write.
// Writes are only accepted while csr_ready (=!busy); writes presented during a rescan are ignored.
module pmp_config_unit #(
   parameter int NPHYS   = 56,
   parameter int NUM_PMP = 5
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              csr_wr,
   output logic                              csr_ready,
   input  logic                              csr_sel_cfg,
   input  logic [3:0]                        csr_idx,
   input  logic [NPHYS-3:0]                  csr_wdata,
   input  logic [3:0]                        csr_rd_idx,
   output logic [7:0]                        csr_rd_cfg,
   output logic [NPHYS-3:0]                  csr_rd_addr,
   output logic                              busy,
   output logic [NUM_PMP-1:0]                pmp_valid,
   output logic [NUM_PMP-1:0]                pmp_locked,
   output logic [NUM_PMP-1:0][2:0]           pmp_prot,
   output logic [NUM_PMP-1:0][NPHYS-3:0]     pmp_start,
   output logic [NUM_PMP-1:0][NPHYS-3:0]     pmp_aend
);
   localparam int AW = NPHYS - 2;

   typedef enum logic {IDLE, SCAN} state_t;

   state_t                   state_q, state_d;
   logic [3:0]               cnt_q, cnt_d;
   logic [7:0]               cfg_q [NUM_PMP];
   logic [7:0]               cfg_d [NUM_PMP];
   logic [AW-1:0]            addr_q [NUM_PMP];
   logic [AW-1:0]            addr_d [NUM_PMP];
   logic [NUM_PMP-1:0]       valid_q, valid_d, locked_q, locked_d;
   logic [NUM_PMP-1:0][2:0]  prot_q, prot_d;
   logic [NUM_PMP-1:0][AW-1:0] start_q, start_d, aend_q, aend_d;

   logic                     wr_acc;
   logic [NUM_PMP:0]         tor_lock;
   logic [7:0]               cur_cfg;
   logic [AW-1:0]            cur_a, cur_prev, napot_mask;

   always_comb begin
      wr_acc = csr_wr && (state_q == IDLE);
      // A locked TOR entry also freezes the pmpaddr below it (its lower bound).
      tor_lock = '0;
      for (int i = 0; i < NUM_PMP; i++)
         tor_lock[i] = cfg_q[i][7] && (cfg_q[i][4:3] == 2'b01);

      cfg_d  = cfg_q;
      addr_d = addr_q;
      for (int i = 0; i < NUM_PMP; i++) begin
         if (wr_acc && (csr_idx == 4'(i))) begin
            if (csr_sel_cfg) begin
               if (!cfg_q[i][7]) cfg_d[i] = {csr_wdata[7], 2'b00, csr_wdata[4:0]};
            end else if (!cfg_q[i][7] && !tor_lock[i+1]) begin
               addr_d[i] = csr_wdata;
            end
         end
      end
   end

   always_comb begin
      cur_cfg  = '0;
      cur_a    = '0;
      cur_prev = '0;
      for (int i = 0; i < NUM_PMP; i++)
         if (cnt_q == 4'(i)) begin
            cur_cfg = cfg_q[i];
            cur_a   = addr_q[i];
         end
      for (int i = 1; i < NUM_PMP; i++)
         if (cnt_q == 4'(i)) cur_prev = addr_q[i-1];
      // a ^ (a+1) sets bit 0..k where k = trailing-ones count; all-ones wraps to all-ones.
      napot_mask = cur_a ^ (cur_a + AW'(1));

      valid_d  = valid_q;
      locked_d = locked_q;
      prot_d   = prot_q;
      start_d  = start_q;
      aend_d   = aend_q;
      if (state_q == SCAN) begin
         for (int i = 0; i < NUM_PMP; i++) begin
            if (cnt_q == 4'(i)) begin
               prot_d[i]   = cur_cfg[2:0];
               locked_d[i] = cur_cfg[7];
               case (cur_cfg[4:3])
                  2'b00: begin
                     valid_d[i] = 1'b0;
                     start_d[i] = '0;
                     aend_d[i]  = '0;
                  end
                  2'b01: begin
                     valid_d[i] = cur_a > cur_prev;
                     start_d[i] = cur_prev;
                     aend_d[i]  = cur_a - AW'(1);
                  end
                  2'b10: begin
                     valid_d[i] = 1'b1;
                     start_d[i] = cur_a;
                     aend_d[i]  = cur_a;
                  end
                  default: begin
                     valid_d[i] = 1'b1;
                     start_d[i] = cur_a & ~napot_mask;
                     aend_d[i]  = cur_a | napot_mask;
                  end
               endcase
            end
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: if (wr_acc) begin
            state_d = SCAN;
            cnt_d   = '0;
         end
         default: begin
            if (cnt_q == 4'(NUM_PMP - 1)) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         valid_q  <= '0;
         locked_q <= '0;
         prot_q   <= '0;
         start_q  <= '0;
         aend_q   <= '0;
         for (int i = 0; i < NUM_PMP; i++) begin
            cfg_q[i]  <= '0;
            addr_q[i] <= '0;
         end
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         valid_q  <= valid_d;
         locked_q <= locked_d;
         prot_q   <= prot_d;
         start_q  <= start_d;
         aend_q   <= aend_d;
         cfg_q    <= cfg_d;
         addr_q   <= addr_d;
      end
   end

   always_comb begin
      csr_rd_cfg  = '0;
      csr_rd_addr = '0;
      for (int i = 0; i < NUM_PMP; i++)
         if (csr_rd_idx == 4'(i)) begin
            csr_rd_cfg  = cfg_q[i];
            csr_rd_addr = addr_q[i];
         end
   end

   assign busy       = (state_q == SCAN);
   assign csr_ready  = !busy;
   assign pmp_valid  = valid_q;
   assign pmp_locked = locked_q;
   assign pmp_prot   = prot_q;
   assign pmp_start  = start_q;
   assign pmp_aend   = aend_q;
endmodule
